// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and bit-period helper.
package uart_pkg;

    localparam int unsigned DataWidth = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_state_e;

    function automatic int unsigned ticks_per_bit(input int unsigned clk_mhz,
                                                  input int unsigned baud);
        return (1000000 * clk_mhz) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handshake and status between uart_rx (master) and its consumer (slave).
interface uart_rx_if;
    import uart_pkg::*;

    logic [DataWidth-1:0] recv_data;
    logic                 recv_valid;
    logic                 recv_ack;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output recv_data, recv_valid, frame_err, overrun, busy,
        input  recv_ack
    );

    modport slave (
        input  recv_data, recv_valid, frame_err, overrun, busy,
        output recv_ack
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// rx synchronizer plus sample value; UART_RX_MAJORITY_EN selects a 2-of-3 vote
// over the synchronized line at s-1, s, s+1 (decision available at s+1).
module uart_rx_sampler (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic rx_i,
    output logic rx_s_o,
    output logic sample_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s_o = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is rxS one cycle back, hist_q[1] two cycles back.
    logic [1:0] hist_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
        end
    end

    assign sample_o = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync_q[1]) |
                      (hist_q[0] & sync_q[1]);
`else
    assign sample_o = sync_q[1];
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ack byte handshake, frame-error pulse and sticky overrun.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (all events one cycle later).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_MHZ = 12,
    parameter int unsigned BAUD    = 9600
) (
    input  logic      clk_i,
    input  logic      resetn_i,
    input  logic      rx_i,
    uart_rx_if.master recv_if
);

    localparam int unsigned T = ticks_per_bit(CLK_MHZ, BAUD);
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned Lag = 1;
`else
    localparam int unsigned Lag = 0;
`endif
    localparam logic [15:0] HalfLoad = 16'(T / 2 - 1 + Lag);
    localparam logic [15:0] FullLoad = 16'(T - 1);

    logic rx_s;
    logic sample;

    uart_rx_sampler u_sampler (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .rx_i     (rx_i),
        .rx_s_o   (rx_s),
        .sample_o (sample)
    );

    uart_state_e          state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 expire;
    logic                 byte_done;

    assign expire = (cnt_q == 16'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        ferr_d    = 1'b0;
        byte_done = 1'b0;

        if (!expire) begin
            cnt_d = cnt_q - 16'd1;
        end

        case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                end
            end
            StStart: begin
                if (expire) begin
                    if (sample) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        cnt_d   = FullLoad;
                        idx_d   = 4'd0;
                    end
                end
            end
            StData: begin
                if (expire) begin
                    shift_d = {sample, shift_q[DataWidth-1:1]};
                    cnt_d   = FullLoad;
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == 4'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (expire) begin
                    if (sample) begin
                        byte_done = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                // A line held low after a bad stop bit must not yield repeated bytes.
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (byte_done) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q & ~recv_if.recv_ack;
        end else if (valid_q && recv_if.recv_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            idx_q   <= 4'd0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign recv_if.recv_data  = data_q;
    assign recv_if.recv_valid = valid_q;
    assign recv_if.frame_err  = ferr_q;
    assign recv_if.overrun    = ovr_q;
    assign recv_if.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames checked every cycle against
// an event-scheduled model of the receiver's outputs (T = 10 clocks per bit).
module tb_uart_rx;

    localparam int unsigned ClkMhz = 1;
    localparam int unsigned Baud   = 100000;
    localparam int          T      = 10;
`ifdef UART_RX_MAJORITY_EN
    localparam int Lag = 1;
`else
    localparam int Lag = 0;
`endif
    // Pin edge to visible output: 2 sync cycles, half bit, 9 bits, 1 register stage.
    localparam int DoneLat = 2 + T / 2 + 9 * T + 1 + Lag;

    typedef struct {
        int         cyc;
        logic       ferr;
        logic [7:0] data;
    } ev_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic rx     = 1'b1;
    int   cyc    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    ev_t        evq[$];
    logic       mon_en    = 1'b0;
    logic       ack_seen  = 1'b0;
    logic       rstn_seen = 1'b0;
    logic       exp_valid = 1'b0;
    logic       exp_ferr  = 1'b0;
    logic       exp_ovr   = 1'b0;
    logic [7:0] exp_data  = 8'h00;

    uart_rx_if rif ();

    uart_rx #(
        .CLK_MHZ (ClkMhz),
        .BAUD    (Baud)
    ) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .rx_i     (rx),
        .recv_if  (rif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) next_cycle();
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (T) next_cycle();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        ev_t ev;
        ev.cyc  = cyc + DoneLat;
        ev.ferr = ~stop;
        ev.data = b;
        evq.push_back(ev);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic ack_pulse();
        rif.recv_ack = 1'b1;
        next_cycle();
        rif.recv_ack = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) next_cycle();
    endtask

    // Model: outputs change only at scheduled frame completions, acks and resets.
    always @(negedge clk) begin
        ev_t  ev;
        logic got_evt;
        if (mon_en) begin
            if (!rstn_seen) begin
                exp_valid = 1'b0;
                exp_ferr  = 1'b0;
                exp_ovr   = 1'b0;
                exp_data  = 8'h00;
                evq.delete();
            end else begin
                got_evt  = 1'b0;
                exp_ferr = 1'b0;
                if (evq.size() > 0 && evq[0].cyc == cyc) begin
                    ev      = evq.pop_front();
                    got_evt = 1'b1;
                end
                if (got_evt && ev.ferr) exp_ferr = 1'b1;
                if (got_evt && !ev.ferr) begin
                    exp_ovr   = exp_valid & ~ack_seen;
                    exp_valid = 1'b1;
                    exp_data  = ev.data;
                end else if (ack_seen && exp_valid) begin
                    exp_valid = 1'b0;
                    exp_ovr   = 1'b0;
                end
            end
            check_eq("outputs{valid,ferr,ovr,data}",
                     {21'd0, rif.recv_valid, rif.frame_err, rif.overrun, rif.recv_data},
                     {21'd0, exp_valid, exp_ferr, exp_ovr, exp_data});
        end
        ack_seen  = rif.recv_ack;
        rstn_seen = resetn;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic rand_done;
        rif.recv_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;

        check_eq("reset_valid", {31'd0, rif.recv_valid}, 32'd0);
        check_eq("reset_data", {24'd0, rif.recv_data}, 32'd0);
        check_eq("reset_busy", {31'd0, rif.busy}, 32'd0);
        check_eq("reset_ovr", {31'd0, rif.overrun}, 32'd0);
        idle(5);

        // Clean frame 0xA5.
        s = cyc;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_until(s + 30);
                check_eq("a5_busy_mid", {31'd0, rif.busy}, 32'd1);
            end
        join
        check_eq("a5_data", {24'd0, rif.recv_data}, 32'hA5);
        check_eq("a5_valid", {31'd0, rif.recv_valid}, 32'd1);
        ack_pulse();
        check_eq("a5_acked", {31'd0, rif.recv_valid}, 32'd0);
        idle(10);

        // 4-cycle glitch: START aborts at D+5 (+Lag), line idle again.
        s = cyc;
        rx = 1'b0;
        repeat (4) next_cycle();
        rx = 1'b1;
        check_eq("glitch_busy_hi", {31'd0, rif.busy}, 32'd1);
        wait_until(s + 2 + 8 + Lag);
        check_eq("glitch_busy_lo", {31'd0, rif.busy}, 32'd0);
        idle(20);

        // Bad stop bit, then a good frame.
        send_frame(8'h3C, 1'b0);
        idle(3);
        check_eq("ferr_no_valid", {31'd0, rif.recv_valid}, 32'd0);
        check_eq("ferr_idle", {31'd0, rif.busy}, 32'd0);
        send_frame(8'h11, 1'b1);
        check_eq("after_ferr_data", {24'd0, rif.recv_data}, 32'h11);
        ack_pulse();
        idle(10);

        // Back-to-back frames without ack: overrun.
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        check_eq("ovr_data", {24'd0, rif.recv_data}, 32'h02);
        check_eq("ovr_flag", {31'd0, rif.overrun}, 32'd1);
        ack_pulse();
        check_eq("ovr_cleared", {31'd0, rif.overrun}, 32'd0);
        check_eq("ovr_valid_cleared", {31'd0, rif.recv_valid}, 32'd0);
        idle(10);

        // Second completion coincides with ack of the first.
        s = cyc;
        fork
            begin
                send_frame(8'h21, 1'b1);
                send_frame(8'h42, 1'b1);
            end
            begin
                wait_until(s + 10 * T + DoneLat - 1);
                ack_pulse();
            end
        join
        check_eq("same_cycle_valid", {31'd0, rif.recv_valid}, 32'd1);
        check_eq("same_cycle_data", {24'd0, rif.recv_data}, 32'h42);
        check_eq("same_cycle_ovr", {31'd0, rif.overrun}, 32'd0);
        idle(5);

        // Byte 0x5A left pending, then reset during data bit 4 of another frame.
        send_frame(8'h5A, 1'b1);
        idle(5);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rx = 1'b0;
        repeat (3) next_cycle();
        resetn = 1'b0;
        rx     = 1'b1;
        next_cycle();
        resetn = 1'b1;
        check_eq("rst_valid", {31'd0, rif.recv_valid}, 32'd0);
        check_eq("rst_data", {24'd0, rif.recv_data}, 32'd0);
        check_eq("rst_busy", {31'd0, rif.busy}, 32'd0);
        idle(2 * T * 10);
        send_frame(8'hFF, 1'b1);
        check_eq("post_rst_data", {24'd0, rif.recv_data}, 32'hFF);
        ack_pulse();
        idle(10);

        // Random frames, gaps, stop bits and acks.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [7:0] b;
                    logic       stop;
                    int         gap;
                    b    = 8'($urandom);
                    stop = ($urandom_range(0, 9) != 0);
                    gap  = $urandom_range(0, 12);
                    if (!stop && gap == 0) gap = 1;
                    send_frame(b, stop);
                    idle(gap);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    rif.recv_ack = ($urandom_range(0, 5) == 0);
                    next_cycle();
                end
                rif.recv_ack = 1'b0;
            end
        join
        idle(3 * T);
        check_eq("events_drained", evq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
